// File: rtl/branch_ctrl.sv
// Branch-resolution sequencer for the ID stage: decodes conditional branches from comparator
// flags, sequences operand-wait stalls, redirects fetch and marks the delay slot.
module branch_ctrl #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             br_valid_i,
    input  logic [2:0]       br_type_i,
    input  logic [2:0]       cmp_rst_i,
    input  logic             opnd_ready_i,
    input  logic             id_stall_i,
    input  logic             exc_flush_i,
    input  logic [31:0]      pc_id_i,
    input  logic [15:0]      imm16_i,
    output logic             br_stall_o,
    output logic             npc_redirect_o,
    output logic [31:0]      npc_target_o,
    output logic             bd_flag_o,
    output logic             wait_err_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 2);
    localparam logic [WaitW-1:0] WaitSat = WaitW'(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitLim = WaitW'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StDslot} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [WaitW-1:0] wait_inc;
    logic             wait_err_q, wait_err_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             taken;
    logic             start;
    logic             resolve;
    logic             br_stall;
    logic             npc_redirect;

    assign npc_target_o = pc_id_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        case (br_type_i)
            3'd0:    taken = cmp_rst_i[0];
            3'd1:    taken = ~cmp_rst_i[0];
            3'd2:    taken = cmp_rst_i[1];
            3'd3:    taken = ~cmp_rst_i[1];
            3'd4:    taken = ~cmp_rst_i[1] | cmp_rst_i[2];
            3'd5:    taken = cmp_rst_i[1] & ~cmp_rst_i[2];
            default: taken = 1'b0;
        endcase
    end

    assign wait_inc = (wait_cnt_q == WaitSat) ? WaitSat : wait_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wait_err_d   = wait_err_q;
        br_stall     = 1'b0;
        npc_redirect = 1'b0;
        resolve      = 1'b0;
        start        = 1'b0;

        unique case (state_q)
            StIdle: start = 1'b1;
            StWait: begin
                if (!br_valid_i) begin
                    // Branch vanished while waiting: abandon it without resolving.
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else if (opnd_ready_i) begin
                    resolve = ~id_stall_i;
                end else begin
                    br_stall   = 1'b1;
                    wait_cnt_d = wait_inc;
                    if (wait_inc > WaitLim) begin
                        wait_err_d = 1'b1;
                    end
                end
            end
            StDslot: begin
                if (!id_stall_i) begin
                    state_d = StIdle;
                    start   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh branch (from idle or sitting in the delay slot) either resolves or starts waiting.
        if (start && br_valid_i && !id_stall_i) begin
            if (opnd_ready_i) begin
                resolve = 1'b1;
            end else begin
                br_stall   = 1'b1;
                state_d    = StWait;
                wait_cnt_d = WaitW'(1);
            end
        end

        if (resolve) begin
            state_d      = StDslot;
            wait_cnt_d   = '0;
            npc_redirect = taken;
        end

        if (exc_flush_i || reset_i) begin
            state_d      = StIdle;
            wait_cnt_d   = '0;
            br_stall     = 1'b0;
            npc_redirect = 1'b0;
            resolve      = 1'b0;
        end

        br_cnt_d    = resolve ? br_cnt_q + 1'b1 : br_cnt_q;
        taken_cnt_d = (resolve && taken) ? taken_cnt_q + 1'b1 : taken_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            wait_err_q  <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            wait_err_q  <= wait_err_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_stall_o     = br_stall;
    assign npc_redirect_o = npc_redirect;
    assign bd_flag_o      = (state_q == StDslot);
    assign wait_err_o     = wait_err_q;
    assign br_cnt_o       = br_cnt_q;
    assign taken_cnt_o    = taken_cnt_q;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch-resolution sequencer in the ID stage of the 5-stage MIPS pipeline. Consumes the 3-bit comparator result vector (bit0 A==B, bit1 A>=0, bit2 A==0) and decodes the six conditional branches from it. Sequences operand-wait stalls, redirects fetch, and marks the delay-slot instruction for CP0 (BD bit). Keeps taken/executed branch statistics.

Parameters:
CNT_W, 32, width of statistics counters
MAX_WAIT, 3, maximum operand-wait cycles before a protocol-error flag

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
br_valid  input  1  ID holds a conditional branch
br_type  input  3  0 BEQ, 1 BNE, 2 BGEZ, 3 BLTZ, 4 BLEZ, 5 BGTZ; 6-7 reserved
cmp_rst  input  3  comparator result {==0, >=0, ==}
opnd_ready  input  1  hazard unit: forwarded operands of the branch are valid this cycle
id_stall  input  1  ID frozen by another hazard (e.g. mult/div busy)
exc_flush  input  1  exception or ERET flushes the pipeline
pc_id  input  32  PC of the branch in ID
imm16  input  16  branch offset
br_stall  output  1  freeze IF/ID because of branch operand wait
npc_redirect  output  1  fetch takes npc_target next edge
npc_target  output  32  pc_id + 4 + (sext(imm16) << 2)
bd_flag  output  1  instruction now in ID is a delay slot
wait_err  output  1  sticky: operand wait exceeded MAX_WAIT
br_cnt  output  CNT_W  resolved branches
taken_cnt  output  CNT_W  taken branches

Behaviour:
- Decode: BEQ=c[0]; BNE=~c[0]; BGEZ=c[1]; BLTZ=~c[1]; BLEZ=~c[1]|c[2]; BGTZ=c[1]&~c[2]; reserved types are never taken but still resolve and count.
- npc_target is always computed combinationally. Addition is modulo 2^32, with silent wrap.
- States: IDLE, WAIT, DSLOT.
- IDLE:
  - If br_valid & ~id_stall & opnd_ready: resolve in this cycle. npc_redirect = taken, combinationally. Next state is DSLOT.
  - If br_valid & ~id_stall & ~opnd_ready: br_stall=1. Next state is WAIT with wait_cnt=1.
  - If br_valid & id_stall: no action; stay in IDLE.
- WAIT:
  - br_stall=1 until opnd_ready. When opnd_ready and ~id_stall, resolve exactly as from IDLE, with br_stall=0 that cycle. Next state is DSLOT.
  - wait_cnt increments each WAIT cycle and saturates. If it exceeds MAX_WAIT, set wait_err (sticky until reset). Stay in WAIT.
  - If br_valid drops in WAIT, that is a protocol violation: go to IDLE, no resolution.
- DSLOT:
  - bd_flag=1 for every cycle in this state, including id_stall cycles. The state holds while id_stall=1.
  - Leave on the first cycle with ~id_stall. Go to IDLE, or resolve immediately if the delay slot is itself a branch (br_valid).
- npc_redirect is only ever asserted in the resolving cycle, and only when taken. It is never asserted during br_stall or id_stall.
- Counters: on each resolution br_cnt += 1, and taken_cnt += 1 if taken. Both wrap modulo 2^CNT_W. They are not affected by exc_flush.
- exc_flush has priority over everything. That cycle forces npc_redirect=0 and br_stall=0, with no resolution and no counting. Next state is IDLE and wait_cnt clears. wait_err is kept.
- Reset values (next edge with reset=1): state IDLE, br_stall 0, npc_redirect 0, bd_flag 0, wait_err 0, wait_cnt 0, br_cnt 0, taken_cnt 0. Reset mid-WAIT or mid-DSLOT aborts the branch with no count.
- Latency: resolution has zero cycles from the last of br_valid, opnd_ready and ~id_stall. bd_flag follows one edge later.

Test Plan:
- BEQ with cmp_rst=3'b001, opnd_ready=1, pc_id=0x3000, imm16=0x0004 -> npc_redirect=1 and npc_target=0x3014 in the same cycle; bd_flag=1 next cycle; br_cnt=1, taken_cnt=1.
- BGTZ with cmp_rst=3'b110 (A==0) -> not taken, npc_redirect=0; BLEZ with the same cmp_rst -> taken; imm16=0xFFFF at pc_id=0x3000 -> npc_target=0x3000.
- BNE with opnd_ready low for 2 cycles -> br_stall=1 for 2 cycles; resolves in cycle 3 with br_stall=0; wait_err stays 0.
- opnd_ready low for 5 cycles (MAX_WAIT=3) -> wait_err rises after cycle 4 and stays 1 after the branch resolves, until reset.
- exc_flush in the same cycle as a resolvable taken BEQ -> npc_redirect=0, counters unchanged, state IDLE; exc_flush during WAIT -> br_stall drops the next cycle.
- Branch in the delay slot with id_stall held 2 cycles in DSLOT -> bd_flag=1 for 3 cycles; then the second branch resolves; br_cnt=2. Reset asserted mid-WAIT -> all outputs 0 the next cycle.
